// File: rtl/dispatch_data_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_data_buffer
// Description : Circular side-buffer holding per-instruction payload (an
//               immediate or a PC) outside the RS entry. Dispatch allocates
//               up to ENQ_WIDTH entries per cycle. Issue reads entries through
//               READ_PORTS registered ports. Commit frees entries in order
//               at the head. Squash rolls the tail back.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               enq_req/data    - per-slot allocate request and payload
//               enq_ready       - any request pattern can be accepted
//               enq_idx         - allocated index (wrap flag + slot) per slot
//               rd_en/idx       - issue read request and index
//               rd_data/err     - registered read data, unallocated flag
//               commit_num      - entries freed at head this cycle
//               squash_vld/idx  - roll tail back to squash_idx
//               count/empty     - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_data_buffer #(
    parameter int DATA_WIDTH   = 20,
    parameter int DEPTH        = 32,
    parameter int ENQ_WIDTH    = 4,
    parameter int READ_PORTS   = 2,
    parameter int COMMIT_WIDTH = 4,
    parameter int IDXW         = $clog2(DEPTH) + 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ENQ_WIDTH-1:0]                   enq_req,
    input  logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0]   enq_data,
    output logic                                   enq_ready,
    output logic [ENQ_WIDTH-1:0][IDXW-1:0]         enq_idx,
    input  logic [READ_PORTS-1:0]                  rd_en,
    input  logic [READ_PORTS-1:0][IDXW-1:0]        rd_idx,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
    output logic [READ_PORTS-1:0]                  rd_err,
    input  logic [$clog2(COMMIT_WIDTH+1)-1:0]      commit_num,
    input  logic                                   squash_vld,
    input  logic [IDXW-1:0]                        squash_idx,
    output logic [$clog2(DEPTH):0]                 count,
    output logic                                   empty
);

    localparam int              SLOTW   = IDXW - 1;
    localparam logic [IDXW-1:0] C_DEPTH = IDXW'(DEPTH);
    localparam logic [IDXW-1:0] C_ENQ   = IDXW'(ENQ_WIDTH);
    localparam logic [IDXW-1:0] C_ONE   = IDXW'(1);

    logic [IDXW-1:0]       r_head;
    logic [IDXW-1:0]       r_tail;
    logic [DEPTH-1:0]      r_valid;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [IDXW-1:0]  w_count;
    logic [IDXW-1:0]  w_enq_cnt;
    logic [IDXW-1:0]  w_commit;
    logic [IDXW-1:0]  w_sq_len;
    logic             w_fire;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_set;

    // Index arithmetic is modulo 2*DEPTH; the extra MSB distinguishes full
    // from empty when the slot fields coincide.
    assign w_count   = r_tail - r_head;
    assign count     = w_count;
    assign empty     = (w_count == '0);
    // Uses only registered state, so it never depends on enq_req.
    assign enq_ready = ((C_DEPTH - w_count) >= C_ENQ);
    assign w_fire    = enq_ready & ~squash_vld;
    assign w_commit  = IDXW'(commit_num);
    assign w_sq_len  = r_tail - squash_idx;

    // Each requesting slot gets tail plus the number of requesters below it.
    always_comb begin
        w_enq_cnt = '0;
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            enq_idx[k] = r_tail;
            if (enq_req[k]) begin
                enq_idx[k] = r_tail + w_enq_cnt;
                w_enq_cnt  = w_enq_cnt + C_ONE;
            end
        end
    end

    // Valid maintenance: commit frees [head, head+commit_num) and squash
    // frees [squash_idx, tail). Distances are taken in slot space so the
    // ranges wrap naturally. Freshly allocated slots lie at or beyond tail,
    // so they never overlap the commit range, and squash suppresses them.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, SLOTW'(i) - r_head[SLOTW-1:0]} < w_commit) begin
                w_clr[i] = 1'b1;
            end
            if (squash_vld && ({1'b0, SLOTW'(i) - squash_idx[SLOTW-1:0]} < w_sq_len)) begin
                w_clr[i] = 1'b1;
            end
        end
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (w_fire && enq_req[k]) begin
                w_set[enq_idx[k][SLOTW-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
        end else begin
            r_head  <= r_head + w_commit;
            r_valid <= (r_valid & ~w_clr) | w_set;
            if (squash_vld) begin
                r_tail <= squash_idx;
            end else if (w_fire) begin
                r_tail <= r_tail + w_enq_cnt;
            end
        end
    end

    // Payload storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (w_fire && enq_req[k]) begin
                r_mem[enq_idx[k][SLOTW-1:0]] <= enq_data[k];
            end
        end
    end

    // Registered read ports; a same-cycle write to the same slot is not
    // forwarded, so the old contents are returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_err  <= '0;
        end else begin
            for (int p = 0; p < READ_PORTS; p++) begin
                if (rd_en[p]) begin
                    rd_data[p] <= r_mem[rd_idx[p][SLOTW-1:0]];
                    rd_err[p]  <= ~r_valid[rd_idx[p][SLOTW-1:0]];
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Freeing more entries than are occupied is a dispatch/commit bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_commit <= w_count);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch_data_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_data_buffer
// Description : Self-checking bench for dispatch_data_buffer. The reference
//               model keeps absolute (never-wrapping) head/tail counters and
//               derives indices, occupancy and allocation status from them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_data_buffer;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        enq_req;
    logic [3:0][19:0]  enq_data;
    logic              enq_ready;
    logic [3:0][5:0]   enq_idx;
    logic [1:0]        rd_en;
    logic [1:0][5:0]   rd_idx;
    logic [1:0][19:0]  rd_data;
    logic [1:0]        rd_err;
    logic [2:0]        commit_num;
    logic              squash_vld;
    logic [5:0]        squash_idx;
    logic [5:0]        count;
    logic              empty;

    dispatch_data_buffer dut (
        .clk(clk), .rst(rst),
        .enq_req(enq_req), .enq_data(enq_data), .enq_ready(enq_ready), .enq_idx(enq_idx),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_err(rd_err),
        .commit_num(commit_num), .squash_vld(squash_vld), .squash_idx(squash_idx),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: absolute positions; slot = pos % 32, index = pos % 64.
    int          m_head, m_tail, sq_abs;
    logic [19:0] m_mem [32];
    logic [19:0] m_rd  [2];
    logic        m_err [2];
    int          total = 0;
    int          bad   = 0;

    function automatic bit m_alloc(int slot);
        return ((slot - (m_head % 32) + 32) % 32) < (m_tail - m_head);
    endfunction

    // Advance the model by one clock using the currently driven inputs,
    // then let the DUT take the same edge.
    task automatic tick();
        int cnt = m_tail - m_head;
        int n   = 0;
        bit rdy = (32 - cnt) >= 4;
        if (rst) begin
            m_head = 0;
            m_tail = 0;
            for (int p = 0; p < 2; p++) begin
                m_rd[p]  = '0;
                m_err[p] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rd_en[p]) begin
                    m_rd[p]  = m_mem[int'(rd_idx[p][4:0])];
                    m_err[p] = !m_alloc(int'(rd_idx[p][4:0]));
                end
            end
            if (rdy && !squash_vld) begin
                for (int k = 0; k < 4; k++) begin
                    if (enq_req[k]) begin
                        m_mem[(m_tail + n) % 32] = enq_data[k];
                        n++;
                    end
                end
                m_tail += n;
            end
            m_head += int'(commit_num);
            if (squash_vld) m_tail = sq_abs;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_req    = '0;
        rd_en      = '0;
        rd_idx     = '0;
        commit_num = '0;
        squash_vld = 1'b0;
        squash_idx = '0;
        for (int k = 0; k < 4; k++) enq_data[k] = 20'($urandom);
    endtask

    task automatic set_squash(int a);
        sq_abs     = a;
        squash_idx = 6'(a % 64);
        squash_vld = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill(int n);
        while (n > 0) begin
            idle();
            enq_req = (n >= 4) ? 4'b1111 : 4'((1 << n) - 1);
            tick();
            n -= (n >= 4) ? 4 : n;
        end
        idle();
    endtask

    task automatic drain(int n);
        while (n > 0) begin
            idle();
            commit_num = (n >= 4) ? 3'd4 : 3'(n);
            tick();
            n -= (n >= 4) ? 4 : n;
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", enq_ready); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        total++; if (rd_err !== 2'b00) begin bad++; $display("FAIL reset_rd_err got=%b exp=00", rd_err); end
    endtask

    task automatic test_alloc();
        logic [19:0] b;
        do_reset();
        enq_req = 4'b1011;
        b = enq_data[1];
        #1;
        total++; if (enq_idx[0] !== 6'd0) begin bad++; $display("FAIL alloc_idx0 got=%0d exp=0", enq_idx[0]); end
        total++; if (enq_idx[1] !== 6'd1) begin bad++; $display("FAIL alloc_idx1 got=%0d exp=1", enq_idx[1]); end
        total++; if (enq_idx[3] !== 6'd2) begin bad++; $display("FAIL alloc_idx3 got=%0d exp=2", enq_idx[3]); end
        tick();
        idle();
        total++; if (count !== 6'd3) begin bad++; $display("FAIL alloc_count got=%0d exp=3", count); end
        rd_en     = 2'b01;
        rd_idx[0] = 6'd1;
        tick();
        idle();
        total++; if (rd_data[0] !== b) begin bad++; $display("FAIL alloc_rd_data got=%h exp=%h", rd_data[0], b); end
        total++; if (rd_err[0] !== 1'b0) begin bad++; $display("FAIL alloc_rd_err got=%b exp=0", rd_err[0]); end
    endtask

    task automatic test_fill();
        do_reset();
        fill(29);
        total++; if (count !== 6'd29) begin bad++; $display("FAIL fill_count got=%0d exp=29", count); end
        total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", enq_ready); end
        enq_req = 4'b1111;
        tick();
        idle();
        total++; if (count !== 6'd29) begin bad++; $display("FAIL fill_blocked_count got=%0d exp=29", count); end
        commit_num = 3'd1;
        tick();
        idle();
        total++; if (count !== 6'd28) begin bad++; $display("FAIL fill_commit_count got=%0d exp=28", count); end
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL fill_commit_ready got=%b exp=1", enq_ready); end
    endtask

    task automatic test_wrap();
        logic [19:0] d2, d3;
        do_reset();
        fill(30);
        drain(30);
        enq_req = 4'b1111;
        d2 = enq_data[2];
        d3 = enq_data[3];
        #1;
        total++; if (enq_idx[0] !== 6'd30) begin bad++; $display("FAIL wrap_idx0 got=%0d exp=30", enq_idx[0]); end
        total++; if (enq_idx[1] !== 6'd31) begin bad++; $display("FAIL wrap_idx1 got=%0d exp=31", enq_idx[1]); end
        total++; if (enq_idx[2] !== 6'd32) begin bad++; $display("FAIL wrap_idx2 got=%0d exp=32", enq_idx[2]); end
        total++; if (enq_idx[3] !== 6'd33) begin bad++; $display("FAIL wrap_idx3 got=%0d exp=33", enq_idx[3]); end
        tick();
        idle();
        total++; if (count !== 6'd4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", count); end
        rd_en  = 2'b11;
        rd_idx = {6'd32, 6'd33};
        tick();
        idle();
        total++; if (rd_data[0] !== d3) begin bad++; $display("FAIL wrap_rd33 got=%h exp=%h", rd_data[0], d3); end
        total++; if (rd_data[1] !== d2) begin bad++; $display("FAIL wrap_rd32 got=%h exp=%h", rd_data[1], d2); end
        total++; if (rd_err !== 2'b00) begin bad++; $display("FAIL wrap_rd_err got=%b exp=00", rd_err); end
    endtask

    task automatic test_squash();
        do_reset();
        fill(10);
        drain(2);
        enq_req = 4'b1111;
        set_squash(6);
        tick();
        idle();
        total++; if (count !== 6'd4) begin bad++; $display("FAIL squash_count got=%0d exp=4", count); end
        enq_req = 4'b0001;
        #1;
        total++; if (enq_idx[0] !== 6'd6) begin bad++; $display("FAIL squash_tail got=%0d exp=6", enq_idx[0]); end
        enq_req = '0;
        rd_en   = 2'b11;
        rd_idx  = {6'd5, 6'd7};
        tick();
        idle();
        total++; if (rd_err !== 2'b01) begin bad++; $display("FAIL squash_rd_err got=%b exp=01", rd_err); end
    endtask

    task automatic test_commit_squash();
        do_reset();
        fill(12);
        drain(4);
        commit_num = 3'd2;
        set_squash(8);
        tick();
        idle();
        total++; if (count !== 6'd2) begin bad++; $display("FAIL csq_count got=%0d exp=2", count); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL csq_empty got=%b exp=0", empty); end
        enq_req = 4'b0001;
        #1;
        total++; if (enq_idx[0] !== 6'd8) begin bad++; $display("FAIL csq_tail got=%0d exp=8", enq_idx[0]); end
        enq_req = '0;
        rd_en   = 2'b11;
        rd_idx  = {6'd6, 6'd5};
        tick();
        idle();
        total++; if (rd_err !== 2'b01) begin bad++; $display("FAIL csq_rd_err got=%b exp=01", rd_err); end
    endtask

    task automatic test_random();
        int cnt, c, n;
        do_reset();
        for (int it = 0; it < 500; it++) begin
            idle();
            cnt = m_tail - m_head;
            enq_req = 4'($urandom);
            c = (cnt < 4) ? cnt : 4;
            commit_num = ($urandom % 3 == 0) ? 3'd0 : 3'($urandom_range(0, c));
            rd_en = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                if ($urandom % 4 == 0) rd_idx[p] = 6'($urandom);
                else rd_idx[p] = 6'(($urandom_range(m_head, m_tail + 1)) % 64);
            end
            if ($urandom % 8 == 0) set_squash($urandom_range(m_head + int'(commit_num), m_tail));
            #1;
            total++; if (count !== 6'(cnt)) begin bad++; $display("FAIL rnd_count it=%0d got=%0d exp=%0d", it, count, cnt); end
            total++; if (empty !== (cnt == 0)) begin bad++; $display("FAIL rnd_empty it=%0d got=%b exp=%b", it, empty, cnt == 0); end
            total++; if (enq_ready !== ((32 - cnt) >= 4)) begin bad++; $display("FAIL rnd_ready it=%0d got=%b exp=%b", it, enq_ready, (32 - cnt) >= 4); end
            n = 0;
            for (int k = 0; k < 4; k++) begin
                if (enq_req[k]) begin
                    total++;
                    if (enq_idx[k] !== 6'((m_tail + n) % 64)) begin
                        bad++;
                        $display("FAIL rnd_enq_idx it=%0d k=%0d got=%0d exp=%0d", it, k, enq_idx[k], (m_tail + n) % 64);
                    end
                    n++;
                end
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                total++; if (rd_err[p] !== m_err[p]) begin bad++; $display("FAIL rnd_rd_err it=%0d p=%0d got=%b exp=%b", it, p, rd_err[p], m_err[p]); end
                if (!m_err[p]) begin
                    total++; if (rd_data[p] !== m_rd[p]) begin bad++; $display("FAIL rnd_rd_data it=%0d p=%0d got=%h exp=%h", it, p, rd_data[p], m_rd[p]); end
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp;
        do_reset();
        fill(20);
        rd_en     = 2'b01;
        rd_idx[0] = 6'd3;
        exp       = m_mem[3];
        tick();
        total++; if (rd_data[0] !== exp) begin bad++; $display("FAIL rmid_pre_rd got=%h exp=%h", rd_data[0], exp); end
        rd_en = 2'b11;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        total++; if (rd_data !== '0) begin bad++; $display("FAIL rmid_rd_data got=%h exp=0", rd_data); end
        total++; if (count !== 6'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rmid_empty got=%b exp=1", empty); end
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", enq_ready); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_head = 0;
        m_tail = 0;
        sq_abs = 0;
        #2;
        test_reset();
        test_alloc();
        test_fill();
        test_wrap();
        test_squash();
        test_commit_squash();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
